// File: rtl/demux1to4_32b_reg_if.sv
// Producer/consumer bundle for the registered 1-to-4 demux: one input stream,
// four independent output lanes with their transfer counters.
interface demux1to4_32b_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [CNT_W-1:0] out_cnt0;
    logic [CNT_W-1:0] out_cnt1;
    logic [CNT_W-1:0] out_cnt2;
    logic [CNT_W-1:0] out_cnt3;

    // Environment side: drives the producer and the lane consumers.
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid,
        input  out_data0, out_data1, out_data2, out_data3,
        input  out_cnt0, out_cnt1, out_cnt2, out_cnt3
    );

    // Demux side.
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid,
        output out_data0, out_data1, out_data2, out_data3,
        output out_cnt0, out_cnt1, out_cnt2, out_cnt3
    );
endinterface

// File: rtl/demux1to4_32b_reg.sv
// Registered 1-to-4 demultiplexer: routes one valid/ready word stream into four
// one-entry lanes, each buffering a word until its consumer takes it.
module demux1to4_32b_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    demux1to4_32b_reg_if.slave   bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [3:0]       lane_valid;
    logic [WIDTH-1:0] lane_data [4];
    logic [CNT_W-1:0] lane_cnt  [4];
    logic             accept;

    // A lane can take a new word when it is empty or draining this very cycle.
    assign bus.in_ready = !flush &&
                          (!lane_valid[bus.in_sel] || bus.out_ready[bus.in_sel]);
    assign accept       = bus.in_valid && bus.in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_lane
            logic [0:0]       state_reg, state_next;
            logic [WIDTH-1:0] data_reg,  data_next;
            logic [CNT_W-1:0] cnt_reg,   cnt_next;
            logic             load;

            assign load = accept && (bus.in_sel == 2'(gi));

            // Flush empties the lane but keeps its word and counter; a load wins
            // over a drain so drain+refill keeps the lane full with no bubble.
            always_comb begin
                state_next = state_reg;
                data_next  = data_reg;
                cnt_next   = cnt_reg;
                if (flush) begin
                    state_next = ST_EMPTY;
                end else if (load) begin
                    state_next = ST_FULL;
                    data_next  = bus.in_data;
                    cnt_next   = cnt_reg + 1'b1;
                end else if (state_reg == ST_FULL && bus.out_ready[gi]) begin
                    state_next = ST_EMPTY;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg <= ST_EMPTY;
                    data_reg  <= '0;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    data_reg  <= data_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign lane_valid[gi] = (state_reg == ST_FULL);
            assign lane_data[gi]  = data_reg;
            assign lane_cnt[gi]   = cnt_reg;
        end
    endgenerate

    assign bus.out_valid = lane_valid;
    assign bus.out_data0 = lane_data[0];
    assign bus.out_data1 = lane_data[1];
    assign bus.out_data2 = lane_data[2];
    assign bus.out_data3 = lane_data[3];
    assign bus.out_cnt0  = lane_cnt[0];
    assign bus.out_cnt1  = lane_cnt[1];
    assign bus.out_cnt2  = lane_cnt[2];
    assign bus.out_cnt3  = lane_cnt[3];
endmodule

// File: tb/tb_demux1to4_32b_reg.sv
// Directed bench for demux1to4_32b_reg: routing, backpressure, drain+refill,
// flush, counter wrap and asynchronous reset with hand-computed expectations.
module tb_demux1to4_32b_reg;
    logic clk;
    logic reset;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    demux1to4_32b_reg_if #(.WIDTH(32), .CNT_W(8)) bus ();

    demux1to4_32b_reg #(.WIDTH(32), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_ready", 64'(bus.in_ready), 64'h1);

        // Route one word to lane 1.
        tick();
        bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 32'hDEADBEEF;
        #1;
        chk("route_ready", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_valid = 1'b0;
        chk("route_valid", 64'(bus.out_valid), 64'h2);
        chk("route_data1", 64'(bus.out_data1), 64'hDEADBEEF);
        chk("route_cnt1", 64'(bus.out_cnt1), 64'h1);

        // Drain lane 1; data is held after the drain.
        bus.out_ready = 4'b0010;
        tick();
        bus.out_ready = 4'b0000;
        chk("drain_valid", 64'(bus.out_valid), 64'h0);
        chk("drain_data1", 64'(bus.out_data1), 64'hDEADBEEF);

        // Backpressure: fill lane 3, then try to overwrite it.
        bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = 32'h33333333;
        tick();
        bus.in_data = 32'h44444444;
        #1;
        chk("bp_ready3", 64'(bus.in_ready), 64'h0);
        tick();
        chk("bp_data3", 64'(bus.out_data3), 64'h33333333);
        chk("bp_cnt3", 64'(bus.out_cnt3), 64'h1);
        chk("bp_valid", 64'(bus.out_valid), 64'h8);
        bus.in_sel = 2'd0; bus.in_data = 32'h1;
        #1;
        chk("bp_ready0", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_valid2", 64'(bus.out_valid), 64'h9);
        chk("bp_data0", 64'(bus.out_data0), 64'h1);

        // Drain+refill on lane 0 in the same cycle.
        bus.out_ready = 4'b0001;
        bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 32'h2;
        #1;
        chk("dr_ready", 64'(bus.in_ready), 64'h1);
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
        chk("dr_valid", 64'(bus.out_valid), 64'h9);
        chk("dr_data0", 64'(bus.out_data0), 64'h2);
        chk("dr_cnt0", 64'(bus.out_cnt0), 64'h2);

        // Ready on an empty lane changes nothing.
        bus.out_ready = 4'b0100;
        tick();
        bus.out_ready = 4'b0000;
        chk("empty_rdy", 64'(bus.out_valid), 64'h9);

        // Fill lanes 1 and 2, then flush with a pending word.
        bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 32'hA1;
        tick();
        bus.in_sel = 2'd2; bus.in_data = 32'hA2;
        tick();
        bus.in_valid = 1'b0;
        chk("fill_valid", 64'(bus.out_valid), 64'hF);
        flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 32'hBAD;
        #1;
        chk("fl_ready", 64'(bus.in_ready), 64'h0);
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("fl_valid", 64'(bus.out_valid), 64'h0);
        chk("fl_cnt0", 64'(bus.out_cnt0), 64'h2);
        chk("fl_cnt1", 64'(bus.out_cnt1), 64'h2);
        chk("fl_cnt2", 64'(bus.out_cnt2), 64'h1);
        chk("fl_cnt3", 64'(bus.out_cnt3), 64'h1);
        chk("fl_data1", 64'(bus.out_data1), 64'hA1);

        // Counter wrap on lane 2 (count starts at 1): stream with drain+refill.
        bus.out_ready = 4'b0100;
        bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 32'h5A5A5A5A;
        repeat (254) @(posedge clk);
        #1;
        chk("wrap_ff", 64'(bus.out_cnt2), 64'hFF);
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 4'b0000;
        chk("wrap_00", 64'(bus.out_cnt2), 64'h00);
        chk("wrap_data2", 64'(bus.out_data2), 64'h5A5A5A5A);
        chk("wrap_valid", 64'(bus.out_valid), 64'h4);

        // Asynchronous reset mid-cycle with lane 2 full.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'h0);
        chk("arst_data2", 64'(bus.out_data2), 64'h0);
        chk("arst_cnt2", 64'(bus.out_cnt2), 64'h0);
        chk("arst_cnt0", 64'(bus.out_cnt0), 64'h0);
        tick();
        reset = 1'b0;
        bus.in_sel = 2'd2;
        #1;
        chk("arst_ready", 64'(bus.in_ready), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
